shiftreg_univ: RTL

- Parametrised universal shift register; next generation of the fixed 8-bit serial-in/serial-out chain.
- Adds WIDTH generalisation, bidirectional shift, parallel load and parallel readout.
- Adds a frame counter that flags each completed WIDTH-bit serial frame.
- Sits between serial links and word-wide datapaths; usable as SIPO, PISO or a bidirectional shifter.

---
 rtl/shiftreg_univ_pkg.sv | 13 +
 rtl/shiftreg_univ_if.sv | 32 +++
 rtl/shiftreg_univ_shift_cell.sv | 52 +++++
 rtl/shiftreg_univ.sv | 117 +++++++++++
 4 files changed

// File: rtl/shiftreg_univ_pkg.sv
// Shared definitions for the universal shift register.
//   shift_mode_t : per-edge operation select (HOLD / SHR / SHL / LOAD).
// Optional feature macro used by the design: SHIFTREG_UNIV_PARITY_EN.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

endpackage : shiftreg_pkg

// File: rtl/shiftreg_univ_if.sv
// Signal bundle for shiftreg_univ (everything except clk/rst).
//   master : drives clr, mode, ser_in_r, ser_in_l, par_in; observes the outputs.
//   slave  : the shift register itself.
// Outputs: par_out, ser_out_r, ser_out_l, bit_cnt, frame_done, parity.
interface shiftreg_univ_if
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic              clr;
  shift_mode_t       mode;
  logic              ser_in_r;
  logic              ser_in_l;
  logic [WIDTH-1:0]  par_in;
  logic [WIDTH-1:0]  par_out;
  logic              ser_out_r;
  logic              ser_out_l;
  logic [CNT_W-1:0]  bit_cnt;
  logic              frame_done;
  logic              parity;

  modport master (
    output clr, mode, ser_in_r, ser_in_l, par_in,
    input  par_out, ser_out_r, ser_out_l, bit_cnt, frame_done, parity
  );

  modport slave (
    input  clr, mode, ser_in_r, ser_in_l, par_in,
    output par_out, ser_out_r, ser_out_l, bit_cnt, frame_done, parity
  );
endinterface : shiftreg_univ_if

// File: rtl/shiftreg_univ_shift_cell.sv
// One bit of the universal shift register: a flop fed by a 4:1 mux
// (hold / right neighbour / left neighbour / load) with synchronous clear.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset (q -> RST_VAL)
//   clr_i   synchronous clear (q -> RST_VAL), overrides mode_i
//   mode_i  operation select
//   right_i value taken on SHR (bit above, or ser_in_r for the MSB)
//   left_i  value taken on SHL (bit below, or ser_in_l for the LSB)
//   load_i  value taken on LOAD
//   q_o     stored bit
module shift_cell
  import shiftreg_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  shift_mode_t mode_i,
  input  logic        right_i,
  input  logic        left_i,
  input  logic        load_i,
  output logic        q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = RST_VAL;
    end else begin
      case (mode_i)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = right_i;
        MODE_SHL:  q_d = left_i;
        MODE_LOAD: q_d = load_i;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : shift_cell

// File: rtl/shiftreg_univ.sv
// Parametrised universal shift register (SIPO / PISO / bidirectional shifter)
// with a frame counter that pulses frame_done on each completed WIDTH-bit frame.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  shiftreg_univ_if.slave: clr, mode, ser_in_r, ser_in_l, par_in in;
//        par_out, ser_out_r, ser_out_l, bit_cnt, frame_done, parity out.
// Optional feature: define SHIFTREG_UNIV_PARITY_EN for a registered even-parity
// bit of q; otherwise parity is tied 0.
module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '1,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst,
  shiftreg_univ_if.slave    bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] right_src;
  logic [WIDTH-1:0] left_src;

  // Neighbour vectors: on SHR each bit takes the one above it, on SHL the one below.
  assign right_src = {bus.ser_in_r, q_q[WIDTH-1:1]};
  assign left_src  = {q_q[WIDTH-2:0], bus.ser_in_l};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      shift_cell #(
        .RST_VAL (RESET_VAL[gi])
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.clr),
        .mode_i  (bus.mode),
        .right_i (right_src[gi]),
        .left_i  (left_src[gi]),
        .load_i  (bus.par_in[gi]),
        .q_o     (q_q[gi])
      );
    end
  endgenerate

  // Frame counter: both shift directions count toward the same frame.
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    if (bus.clr) begin
      bit_cnt_d = '0;
    end else begin
      case (bus.mode)
        MODE_SHR, MODE_SHL: begin
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        MODE_LOAD: bit_cnt_d = '0;
        default:   bit_cnt_d = bit_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SHIFTREG_UNIV_PARITY_EN
  // Parity of the next q is tracked incrementally: a shift drops one bit and
  // adds one, so the new parity is the old one with both of those bits folded in.
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (bus.clr) begin
      parity_d = ^RESET_VAL;
    end else begin
      case (bus.mode)
        MODE_SHR:  parity_d = parity_q ^ q_q[0] ^ bus.ser_in_r;
        MODE_SHL:  parity_d = parity_q ^ q_q[WIDTH-1] ^ bus.ser_in_l;
        MODE_LOAD: parity_d = ^bus.par_in;
        default:   parity_d = parity_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_q <= ^RESET_VAL;
    else      parity_q <= parity_d;
  end

  assign bus.parity = parity_q;
`else
  assign bus.parity = 1'b0;
`endif

  assign bus.par_out    = q_q;
  assign bus.ser_out_r  = q_q[0];
  assign bus.ser_out_l  = q_q[WIDTH-1];
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.frame_done = frame_done_q;

endmodule : shiftreg_univ
